// File: rtl/loop_recorder.sv
// loop_recorder: captures signed audio samples into block RAM while recording,
// then loops playback of the clip; overdub mixes live input into the stored
// loop with saturation. Reads use a two-stage pipeline (BRAM reg + output reg).
module loop_recorder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 65536,
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    record_in,
    input  logic                    overdub_in,
    input  logic                    audio_valid_in,
    input  logic signed [WIDTH-1:0] audio_in,
    output logic signed [WIDTH-1:0] audio_out,
    output logic                    audio_valid_out,
    output logic [LEN_W-1:0]        length,
    output logic                    full_out
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY, S_OVERDUB} state_t;

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_q;
    logic [AW-1:0]    addr_q;
    logic [LEN_W-1:0] length_q;
    logic             full_q;

    // read stage 1: BRAM output plus the context needed for write-back
    logic [WIDTH-1:0] rdata_q;
    logic             rd_vld_q;
    logic             rd_ovd_q;
    logic [AW-1:0]    rd_addr_q;
    logic [WIDTH-1:0] din_q;

    // read stage 2: registered playback output
    logic [WIDTH-1:0] out_q;
    logic             out_vld_q;

    logic             active;
    logic             squash;
    logic             launch;
    logic             rec_wr;
    logic             wb_wr;
    logic             we;
    logic             last_addr;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mix;

    // Datapath decode: launch/squash decisions, write-port mux and saturating mix
    always_comb begin
        active    = (state_q == S_PLAY) || (state_q == S_OVERDUB);
        // leaving playback for RECORD kills the in-flight output and write-back
        squash    = active && record_in;
        launch    = active && !record_in && audio_valid_in;
        rec_wr    = (state_q == S_RECORD) && record_in && audio_valid_in &&
                    (length_q < DEPTH_L) && !rst_in;
        wb_wr     = rd_vld_q && rd_ovd_q && !squash && !rst_in;
        we        = rec_wr || wb_wr;
        last_addr = (LEN_W'(addr_q) == (length_q - 1'b1));
        sum       = {rdata_q[WIDTH-1], rdata_q} + {din_q[WIDTH-1], din_q};
        mix       = sum[WIDTH-1:0];
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            mix = sum[WIDTH] ? SAT_MIN : SAT_MAX;
        end
        waddr     = rec_wr ? addr_q : rd_addr_q;
        wdata     = rec_wr ? audio_in : mix;
    end

    // Sample memory: single write port (capture or overdub write-back), registered read
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (launch) begin
            rdata_q <= mem[addr_q];
        end
    end

    // Control FSM, address/length bookkeeping and read pipeline registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            length_q  <= '0;
            full_q    <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_ovd_q  <= 1'b0;
            rd_addr_q <= '0;
            din_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= launch;
            if (launch) begin
                rd_ovd_q  <= (state_q == S_OVERDUB);
                rd_addr_q <= addr_q;
                din_q     <= audio_in;
            end
            out_vld_q <= rd_vld_q && !squash;
            if (rd_vld_q && !squash) begin
                out_q <= rdata_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (record_in) begin
                        state_q  <= S_RECORD;
                        addr_q   <= '0;
                        length_q <= '0;
                        full_q   <= 1'b0;
                    end
                end
                S_RECORD: begin
                    if (!record_in) begin
                        state_q <= (length_q != '0) ? S_PLAY : S_IDLE;
                        addr_q  <= '0;
                    end else if (rec_wr) begin
                        addr_q   <= addr_q + 1'b1;
                        length_q <= length_q + 1'b1;
                        if ((length_q + 1'b1) == DEPTH_L) begin
                            full_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (record_in) begin
                        state_q  <= S_RECORD;
                        addr_q   <= '0;
                        length_q <= '0;
                        full_q   <= 1'b0;
                    end else begin
                        state_q <= overdub_in ? S_OVERDUB : S_PLAY;
                        if (launch) begin
                            addr_q <= last_addr ? '0 : addr_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign audio_out       = out_q;
    assign audio_valid_out = out_vld_q;
    assign length          = length_q;
    assign full_out        = full_q;

endmodule

// File: tb/tb_loop_recorder.sv
// tb_loop_recorder: directed scenarios, a saturation vector table and a random
// phase, all checked against an event-queue reference model of the recorder.
module tb_loop_recorder;
    localparam int TW     = 8;
    localparam int TDEPTH = 16;
    localparam int TLW    = $clog2(TDEPTH + 1);

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 record_in;
    logic                 overdub_in;
    logic                 audio_valid_in;
    logic signed [TW-1:0] audio_in;
    logic signed [TW-1:0] audio_out;
    logic                 audio_valid_out;
    logic [TLW-1:0]       length;
    logic                 full_out;

    loop_recorder #(.WIDTH(TW), .DEPTH(TDEPTH)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .record_in       (record_in),
        .overdub_in      (overdub_in),
        .audio_valid_in  (audio_valid_in),
        .audio_in        (audio_in),
        .audio_out       (audio_out),
        .audio_valid_out (audio_valid_out),
        .length          (length),
        .full_out        (full_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_REC, M_PLAY, M_OVD} mmode_t;
    typedef struct {
        int due;
        int idx;
        int val;
        int din;
        bit ovd;
    } pend_t;

    mmode_t m_mode = M_IDLE;
    int     clip[$];
    pend_t  pend[$];
    int     m_pos  = 0;
    int     m_full = 0;
    int     m_vout = 0;
    int     m_out  = 0;
    int     m_cyc  = 0;

    function automatic int sat(int a, int b);
        int s;
        s = a + b;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    // Advance the model by one clock edge using the inputs sampled at that edge.
    function automatic void model_edge();
        bit    act;
        pend_t p;
        m_cyc++;
        m_vout = 0;
        if (rst_in) begin
            m_mode = M_IDLE; clip.delete(); pend.delete();
            m_pos = 0; m_full = 0; m_out = 0;
            return;
        end
        act = (m_mode == M_PLAY) || (m_mode == M_OVD);
        if (act && record_in) begin
            pend.delete();
            m_mode = M_REC; clip.delete(); m_pos = 0; m_full = 0;
            return;
        end
        if (act && audio_valid_in) begin
            p.due = m_cyc + 1; p.idx = m_pos; p.val = clip[m_pos];
            p.din = int'(audio_in); p.ovd = (m_mode == M_OVD);
            pend.push_back(p);
            m_pos = (m_pos + 1) % clip.size();
        end
        while (pend.size() > 0 && pend[0].due == m_cyc) begin
            p = pend.pop_front();
            m_vout = 1;
            m_out  = p.val;
            if (p.ovd) clip[p.idx] = sat(p.val, p.din);
        end
        case (m_mode)
            M_IDLE: if (record_in) begin
                m_mode = M_REC; clip.delete(); m_pos = 0; m_full = 0;
            end
            M_REC: begin
                if (!record_in) begin
                    m_mode = (clip.size() > 0) ? M_PLAY : M_IDLE;
                    m_pos  = 0;
                end else if (audio_valid_in && clip.size() < TDEPTH) begin
                    clip.push_back(int'(audio_in));
                    if (clip.size() == TDEPTH) m_full = 1;
                end
            end
            default: m_mode = overdub_in ? M_OVD : M_PLAY;
        endcase
    endfunction

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
    task automatic step(input bit rs, input bit r, input bit o, input bit v, input int d);
        rst_in = rs; record_in = r; overdub_in = o; audio_valid_in = v; audio_in = 8'(d);
        @(posedge clk_in);
        model_edge();
        #1;
        chk("model_vout", int'(audio_valid_out), m_vout);
        chk("model_out", int'(audio_out), m_out);
        chk("model_len", int'(length), clip.size());
        chk("model_full", int'(full_out), m_full);
    endtask

    // One playback strobe, then check the output lands exactly two cycles later as a single pulse.
    task automatic play_strobe(input bit o, input int din, input int exp, input int gap, input string name);
        step(0, 0, o, 1, din);
        chk({name, "_lat"}, int'(audio_valid_out), 0);
        step(0, 0, o, 0, 0);
        chk({name, "_vld"}, int'(audio_valid_out), 1);
        chk(name, int'(audio_out), exp);
        step(0, 0, o, 0, 0);
        chk({name, "_pulse"}, int'(audio_valid_out), 0);
        for (int k = 3; k < gap; k++) step(0, 0, o, 0, 0);
    endtask

    typedef struct {
        int stored;
        int din;
        int mixed;
    } sat_vec_t;

    sat_vec_t sv[8];

    bit r_rec, r_ovd, r_rst, r_v;
    int last_v;

    initial begin
        sv[0] = '{100, 50, 127};
        sv[1] = '{-100, -50, -128};
        sv[2] = '{10, 5, 15};
        sv[3] = '{0, -3, -3};
        sv[4] = '{127, 1, 127};
        sv[5] = '{-128, -1, -128};
        sv[6] = '{-1, 1, 0};
        sv[7] = '{60, 60, 120};

        rst_in = 1'b1; record_in = 1'b0; overdub_in = 1'b0;
        audio_valid_in = 1'b0; audio_in = '0;

        // reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_vout", int'(audio_valid_out), 0);
        chk("rst_out", int'(audio_out), 0);
        chk("rst_len", int'(length), 0);
        chk("rst_full", int'(full_out), 0);
        step(0, 0, 0, 0, 0);

        // ten samples on consecutive cycles, then wrapped playback every 7 cycles
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 1, i);
        chk("t1_len", int'(length), 10);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) play_strobe(0, 0, i % 10, 7, "t1_play");

        // overflow: 20 samples into a 16-deep loop
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 1, i);
        chk("t2_len", int'(length), 16);
        chk("t2_full", int'(full_out), 1);
        step(0, 0, 0, 0, 0);
        chk("t2_full_hold", int'(full_out), 1);
        for (int i = 0; i < 17; i++) play_strobe(0, 0, i % 16, 3, "t2_play");

        // saturating overdub table: record, overdub one pass, play back
        step(0, 1, 0, 0, 0);
        for (int j = 0; j < 8; j++) step(0, 1, 0, 1, sv[j].stored);
        chk("t3_len", int'(length), 8);
        chk("t3_full", int'(full_out), 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int j = 0; j < 8; j++) play_strobe(1, sv[j].din, sv[j].stored, 4, "t3_premix");
        step(0, 0, 0, 0, 0);
        for (int j = 0; j < 8; j++) play_strobe(0, 0, sv[j].mixed, 4, "t3_mixed");

        // record with no samples returns to IDLE with an empty loop
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        chk("t4_len_rec", int'(length), 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0);
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            chk("t4_no_vout", int'(audio_valid_out), 0);
        end
        chk("t4_len", int'(length), 0);

        // record_in raised one cycle after a strobe squashes that strobe's output
        step(0, 1, 0, 0, 0);
        for (int i = 7; i < 10; i++) step(0, 1, 0, 1, i);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("t5_lat", int'(audio_valid_out), 0);
        step(0, 1, 0, 0, 0);
        chk("t5_squash", int'(audio_valid_out), 0);
        chk("t5_len0", int'(length), 0);
        step(0, 1, 0, 1, 30);
        chk("t5_len1", int'(length), 1);
        chk("t5_after", int'(audio_valid_out), 0);
        step(0, 1, 0, 1, 40);
        chk("t5_len2", int'(length), 2);
        step(0, 0, 0, 0, 0);

        // reset inside the overdub read-modify-write window
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 5);
        step(1, 0, 1, 0, 0);
        chk("t6_vout", int'(audio_valid_out), 0);
        chk("t6_out", int'(audio_out), 0);
        chk("t6_len", int'(length), 0);
        chk("t6_full", int'(full_out), 0);
        chk("t6_mem", int'($signed(dut.mem[0])), 30);
        step(0, 0, 0, 0, 0);

        // random phase against the model
        r_rec = 0; r_ovd = 0; last_v = -100;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(29) == 0) r_rec = !r_rec;
            if ($urandom_range(19) == 0) r_ovd = !r_ovd;
            r_rst = ($urandom_range(599) == 0);
            r_v   = ($urandom_range(1) == 1);
            if ((m_mode == M_OVD || r_ovd) && (m_cyc + 1 - last_v) < 3) r_v = 0;
            if (r_v) last_v = m_cyc + 1;
            step(r_rst, r_rec, r_ovd, r_v, int'($urandom_range(255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
